// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter
// Shares one 16x2 character LCD byte writer between N_REQ screen producers.
// Each frame it picks an owner (producer 0 = alert, fixed priority; others
// round-robin with a minimum dwell), latches that producer's 32-character
// frame and streams 0x80, 16 line-1 chars, 0xC0, 16 line-2 chars, followed by
// an idle gap before the next arbitration.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en_i            enable; dropping it lets the current frame finish, then idle
//   req_i           per-producer level request (bit 0 = alert)
//   frames_i        producer i frame at [256*i +: 256], byte k at [8k +: 8]
//   wr_valid_o      byte offered to the LCD writer
//   wr_ready_i      LCD writer accepts the byte
//   wr_rs_o         0 = command byte, 1 = character byte
//   wr_data_o       byte value
//   grant_o         one-hot owner of the frame in progress, 0 when idle
//   frame_done_o    one-cycle pulse after the last character is accepted
//   busy_o          high in every state except IDLE
//   state_dbg_o     current FSM state
//
// Handshake: a byte moves on a rising edge where wr_valid_o=1 and
// wr_ready_i=1; wr_valid_o/wr_rs_o/wr_data_o are registered and held stable
// until that edge, and the next byte is offered in the following cycle.
module lcd_frame_arbiter #(
  parameter int N_REQ        = 3,
  parameter int DWELL_CYCLES = 150_000_000,
  parameter int GAP_CYCLES   = 50_000,
  parameter int TMR_W        = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [256*N_REQ-1:0] frames_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic                 wr_rs_o,
  output logic [7:0]           wr_data_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 frame_done_o,
  output logic                 busy_o,
  output logic [2:0]           state_dbg_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TMR_W-1:0] DWELL_T = TMR_W'(DWELL_CYCLES);
  localparam logic [TMR_W-1:0] GAP_T   = TMR_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_CMD1  = 3'd2,
    S_LINE1 = 3'd3,
    S_CMD2  = 3'd4,
    S_LINE2 = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               done_q, done_d;
  logic [255:0]       buf_q, buf_d;
  logic [3:0]         idx_q, idx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [TMR_W-1:0]   dwell_q, dwell_d;
  logic [TMR_W-1:0]   gap_q, gap_d;

  logic               arb_found;
  logic               arb_rotate;
  logic [PTR_W-1:0]   arb_owner;
  logic [PTR_W-1:0]   cand;
  logic               xfer;

  function automatic logic [7:0] byte_of(input logic [255:0] b, input logic [4:0] k);
    return b[{k, 3'b000} +: 8];
  endfunction

  assign xfer = valid_q && wr_ready_i;

  // Owner selection. The search order after the pointer p is p+1..N_REQ-1,
  // then 1..p, so a lone requester p is found last and still rotates
  // (which clears its dwell timer).
  always_comb begin
    arb_found  = 1'b0;
    arb_rotate = 1'b0;
    arb_owner  = ptr_q;
    cand       = ptr_q;
    if (req_i[0]) begin
      arb_found = 1'b1;
      arb_owner = '0;
    end else if (req_i[ptr_q] && (dwell_q < DWELL_T)) begin
      arb_found = 1'b1;
    end else begin
      for (int k = 1; k < N_REQ; k++) begin
        cand = PTR_W'(((int'(ptr_q) - 1 + k) % (N_REQ - 1)) + 1);
        if (!arb_found && req_i[cand]) begin
          arb_found  = 1'b1;
          arb_rotate = 1'b1;
          arb_owner  = cand;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rs_d    = rs_q;
    data_d  = data_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    buf_d   = buf_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;

    // Dwell runs for a non-alert owner through the whole frame and its gap,
    // saturating so a long tenure never wraps back under the limit.
    if ((state_q != S_IDLE) && (state_q != S_ARB) && (grant_q != '0) &&
        !grant_q[0] && (dwell_q != DWELL_T)) begin
      dwell_d = dwell_q + TMR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (en_i && (req_i != '0)) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == arb_owner) buf_d = frames_i[256*i +: 256];
          end
          grant_d            = '0;
          grant_d[arb_owner] = 1'b1;
          if (arb_rotate) begin
            ptr_d   = arb_owner;
            dwell_d = '0;
          end
          state_d = S_CMD1;
          valid_d = 1'b1;
          rs_d    = 1'b0;
          data_d  = 8'h80;
        end else begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      S_CMD1: begin
        if (xfer) begin
          state_d = S_LINE1;
          rs_d    = 1'b1;
          data_d  = byte_of(buf_q, 5'd0);
          idx_d   = 4'd0;
        end
      end
      S_LINE1: begin
        if (xfer) begin
          if (idx_q == 4'd15) begin
            state_d = S_CMD2;
            rs_d    = 1'b0;
            data_d  = 8'hC0;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = byte_of(buf_q, {1'b0, idx_q + 4'd1});
          end
        end
      end
      S_CMD2: begin
        if (xfer) begin
          state_d = S_LINE2;
          rs_d    = 1'b1;
          data_d  = byte_of(buf_q, 5'd16);
          idx_d   = 4'd0;
        end
      end
      S_LINE2: begin
        if (xfer) begin
          if (idx_q == 4'd15) begin
            state_d = S_GAP;
            valid_d = 1'b0;
            rs_d    = 1'b0;
            data_d  = 8'h00;
            done_d  = 1'b1;
            gap_d   = '0;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = byte_of(buf_q, {1'b1, idx_q + 4'd1});
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_T) begin
          gap_d = '0;
          if (en_i && (req_i != '0)) begin
            state_d = S_ARB;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end else begin
          gap_d = gap_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      grant_q <= '0;
      done_q  <= 1'b0;
      buf_q   <= '0;
      idx_q   <= 4'd0;
      ptr_q   <= PTR_W'(1);
      dwell_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
    end
  end

  assign wr_valid_o   = valid_q;
  assign wr_rs_o      = rs_q;
  assign wr_data_o    = data_q;
  assign grant_o      = grant_q;
  assign frame_done_o = done_q;
  assign busy_o       = (state_q != S_IDLE);
  assign state_dbg_o  = state_q;

endmodule

// File: doc/lcd_frame_arbiter.md
Name: lcd_frame_arbiter

Overview:
Shares the single 16x2 character LCD writer between several screen producers, such as the odometer/fuel page, the trip page and the side-brake alert. It selects one producer per frame and latches that producer's 32-character frame. It then streams the frame as a byte sequence to the downstream LCD byte writer: a 0x80 command, 16 data bytes, a 0xC0 command, then 16 more data bytes. Producer 0 is the alert source and has fixed priority. All other producers rotate round-robin, each holding the screen for a dwell time.

Parameters:
N_REQ, 3, number of producers (2..8); index 0 is the alert producer.
DWELL_CYCLES, 150_000_000, minimum cycles a non-alert producer keeps the screen before rotation (3 s at 50 MHz).
GAP_CYCLES, 50_000, idle cycles inserted after each complete frame before the next arbitration.
TMR_W, 28, width of the dwell and gap counters; must hold max(DWELL_CYCLES, GAP_CYCLES).

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-high.
en  in  1  enable; when it goes low, the current frame completes, then the block idles.
req  in  N_REQ  per-producer request; level-sensitive.
frames  in  256*N_REQ  producer i frame at frames[256*i +: 256]; byte k at [8k+7:8k]; k=0..15 is line 1, k=16..31 is line 2.
wr_valid  out  1  byte available to the LCD writer.
wr_ready  in  1  LCD writer accepts the byte.
wr_rs  out  1  0 = command byte, 1 = character byte.
wr_data  out  8  byte value.
grant  out  N_REQ  one-hot owner of the frame in progress; 0 when idle.
frame_done  out  1  one-cycle pulse on acceptance of the 32nd character.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: wr_valid=0, wr_rs=0, wr_data=0, grant=0, frame_done=0, busy=0. Internally: state=IDLE, dwell timer=0, gap counter=0, rotation pointer=1, character index=0.
- Reset is asynchronous and may occur mid-frame. wr_valid drops immediately and the partial frame is abandoned; the next frame rewrites both lines from address 0x80.
- States:
  - IDLE: go to ARB when en=1 and req!=0.
  - ARB: exactly one cycle. Choose the owner, latch frames[owner] into a 256-bit buffer, set grant, go to CMD1.
  - CMD1: present rs=0, data=0x80.
  - LINE1: present rs=1, data=buf byte idx, idx 0..15.
  - CMD2: present rs=0, data=0xC0.
  - LINE2: present rs=1, data=buf byte 16+idx.
  - GAP: count GAP_CYCLES, then go to ARB if en=1 and req!=0, else IDLE (grant cleared).
- Handshake:
  - A byte transfers on a rising edge where wr_valid=1 and wr_ready=1.
  - wr_valid, wr_rs and wr_data are registered and held stable until transfer.
  - The next byte is presented in the cycle after transfer; with wr_ready held at 1, there is one byte per cycle.
  - wr_valid is 0 in IDLE, ARB and GAP.
- Latency: with wr_ready=1, wr_valid with 0x80 is high on the second cycle after leaving IDLE (ARB, then CMD1).
- Frame latched at ARB: later changes to frames or req do not alter the frame in progress, so there is no tearing.
- Arbitration in ARB:
  1. If req[0]=1, the owner is 0. The dwell timer is held, and the rotation pointer is unchanged.
  2. Otherwise, if the current non-alert owner p (the rotation pointer) still requests and the dwell timer < DWELL_CYCLES, the owner stays p.
  3. Otherwise, the owner is the first requesting index after p in the order p+1..N_REQ-1, then 1..p, with wrap. The pointer is updated and the dwell timer cleared. If only p requests, p is kept and the timer cleared.
  4. If no non-alert request exists and req[0]=0, go to IDLE.
- Dwell timer: increments every cycle while the owner is non-alert, whether busy or in GAP. It saturates at DWELL_CYCLES and never wraps.
- Preemption happens only at frame boundaries. An alert raised mid-frame waits for the current frame and its GAP.
- en=0: in-progress bytes still complete; after GAP the block enters IDLE. en=0 in IDLE keeps it idle.
- frame_done pulses once per completed frame, coincident with the cycle after the last transfer, as the state enters GAP.
- Simultaneous events: req rising in the same cycle as the ARB evaluation is seen. A req that drops during a frame affects only the next ARB.

Test Plan:
(Sim parameters: DWELL_CYCLES=1000, GAP_CYCLES=10, N_REQ=3.)
- Single producer: req=3'b010, frame1 holds "ODO: 01234 km" / " FUEL: 50 %", wr_ready=1 -> sequence 0x80, 16 line-1 bytes, 0xC0, 16 line-2 bytes; grant=010; frame_done after byte 34; frame repeats every 35+10+1 cycles.
- Backpressure: wr_ready toggles 1-of-3 cycles randomly -> identical 34-byte order, wr_data/wr_rs stable while wr_valid=1 and wr_ready=0, and no byte is dropped or duplicated.
- Rotation: req=3'b110 -> producer 1 is shown for at least 1000 cycles of frames, then producer 2, then producer 1 again. Grant changes only in ARB.
- Alert preemption: req[0] raised mid-frame of producer 2 -> producer 2 frame completes, then grant=001 from the next frame. When req[0] drops, producer 2 resumes with the dwell timer not reset.
- Tearing: change frames[1] while line 1 is being sent -> the current frame is the old content and the next frame is the new content.
- Reset and en: assert rst at byte 7 -> all outputs 0 on the same cycle; after release, the frame restarts with 0x80. en=0 mid-frame -> the frame completes, GAP runs, IDLE is entered, busy=0, grant=0.
